// File: rtl/sys_bus_responder.sv
// rtl/sys_bus_responder.sv - wait-stated byte bus responder: RAM plus LED/HEX/switch MMIO; SYS_BUS_ERR_EN adds resp_err
module sys_bus_responder #(
    parameter int WAIT_STATES = 2,
    parameter int MEM_AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wren,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [9:0]  sw_in,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic [9:0]  ledr_out,
    output logic [23:0] hex_val
`ifdef SYS_BUS_ERR_EN
    ,
    output logic        resp_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;
    logic        cap_wren;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;
    logic        eff_wren;
    logic [15:0] eff_addr;
    logic [7:0]  eff_wdata;
    logic        enter_resp;
    logic        in_ram;
    logic [7:0]  rd_mux;

    logic [7:0] mem [2**MEM_AW];

    // With zero wait states the access commits on the acceptance edge itself,
    // before the captured copy exists, so the live request is used in IDLE.
    assign eff_wren   = (state == IDLE) ? req_wren  : cap_wren;
    assign eff_addr   = (state == IDLE) ? req_addr  : cap_addr;
    assign eff_wdata  = (state == IDLE) ? req_wdata : cap_wdata;
    assign enter_resp = (next_state == RESP);
    assign in_ram     = ((eff_addr >> MEM_AW) == 16'd0);

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = req_valid ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE;
            WAIT:    next_state = (wait_cnt == LAST_WAIT) ? RESP : WAIT;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_wren  <= 1'b0;
            cap_addr  <= 16'h0000;
            cap_wdata <= 8'h00;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (state == IDLE && req_valid) begin
                cap_wren  <= req_wren;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (in_ram) begin
            rd_mux = mem[eff_addr[MEM_AW-1:0]];
        end else begin
            case (eff_addr)
                16'hFF00: rd_mux = ledr_out[7:0];
                16'hFF01: rd_mux = {6'b0, ledr_out[9:8]};
                16'hFF02: rd_mux = hex_val[7:0];
                16'hFF03: rd_mux = hex_val[15:8];
                16'hFF04: rd_mux = hex_val[23:16];
                16'hFF08: rd_mux = sw_in[7:0];
                16'hFF09: rd_mux = {6'b0, sw_in[9:8]};
                default:  rd_mux = 8'h00;
            endcase
        end
    end

    // RAM has no reset; rst gates the write so an edge during reset cannot commit.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && eff_wren && in_ram)
            mem[eff_addr[MEM_AW-1:0]] <= eff_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 8'h00;
            ledr_out   <= 10'h000;
            hex_val    <= 24'h000000;
        end else begin
            resp_valid <= enter_resp;
            resp_rdata <= (enter_resp && !eff_wren) ? rd_mux : 8'h00;
            if (enter_resp && eff_wren) begin
                case (eff_addr)
                    16'hFF00: ledr_out[7:0]  <= eff_wdata;
                    16'hFF01: ledr_out[9:8]  <= eff_wdata[1:0];
                    16'hFF02: hex_val[7:0]   <= eff_wdata;
                    16'hFF03: hex_val[15:8]  <= eff_wdata;
                    16'hFF04: hex_val[23:16] <= eff_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef SYS_BUS_ERR_EN
    logic acc_err;

    always_comb begin
        acc_err = 1'b0;
        if (!in_ram) begin
            case (eff_addr)
                16'hFF00, 16'hFF01, 16'hFF02, 16'hFF03, 16'hFF04: acc_err = 1'b0;
                16'hFF08, 16'hFF09: acc_err = eff_wren;
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) resp_err <= 1'b0;
        else      resp_err <= enter_resp && acc_err;
    end
`endif

endmodule

// File: tb/tb_sys_bus_responder.sv
// tb/tb_sys_bus_responder.sv - scoreboard bench for sys_bus_responder (WAIT_STATES=2 and WAIT_STATES=0 instances)
module tb_sys_bus_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wren;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic [9:0]  sw_in;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic [9:0]  ledr_out;
    logic [23:0] hex_val;
    logic        req0_valid, req0_wren;
    logic [15:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        resp0_valid;
    logic [7:0]  resp0_rdata;
    logic [9:0]  ledr0_out;
    logic [23:0] hex0_val;
`ifdef SYS_BUS_ERR_EN
    logic        resp_err, resp0_err;
`endif

    always #5 clk = ~clk;

    sys_bus_responder #(.WAIT_STATES(WS), .MEM_AW(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wren(req_wren),
        .req_addr(req_addr), .req_wdata(req_wdata), .sw_in(sw_in),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ledr_out(ledr_out), .hex_val(hex_val)
`ifdef SYS_BUS_ERR_EN
        , .resp_err(resp_err)
`endif
    );

    sys_bus_responder #(.WAIT_STATES(0), .MEM_AW(10)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req0_valid), .req_wren(req0_wren),
        .req_addr(req0_addr), .req_wdata(req0_wdata), .sw_in(sw_in),
        .resp_valid(resp0_valid), .resp_rdata(resp0_rdata),
        .ledr_out(ledr0_out), .hex_val(hex0_val)
`ifdef SYS_BUS_ERR_EN
        , .resp_err(resp0_err)
`endif
    );

    typedef struct {
        bit          is_rd;
        logic [7:0]  rd;
        bit          err;
        logic [9:0]  led;
        logic [23:0] hex;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        q0[$];
    exp_t        mon_e, mon0_e;
    logic [7:0]  ram_m [int];
    logic [9:0]  led_m = '0;
    logic [23:0] hex_m = '0;
    int          wr_addrs[$];
    int          total = 0, bad = 0, cyc = 0, prev0 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input bit wr, input logic [15:0] a, input logic [7:0] d,
                                   input logic [9:0] sw, input int acc);
        exp_t e;
        bit   mapped = 1'b1;
        e.is_rd = !wr;
        e.rd    = 8'h00;
        e.acc   = acc;
        if (int'(a) < 1024) begin
            if (wr) ram_m[int'(a)] = d;
            else if (ram_m.exists(int'(a))) e.rd = ram_m[int'(a)];
            else e.is_rd = 1'b0;
        end else begin
            case (a)
                16'hFF00: if (wr) led_m[7:0] = d;      else e.rd = led_m[7:0];
                16'hFF01: if (wr) led_m[9:8] = d[1:0]; else e.rd = {6'b0, led_m[9:8]};
                16'hFF02: if (wr) hex_m[7:0] = d;      else e.rd = hex_m[7:0];
                16'hFF03: if (wr) hex_m[15:8] = d;     else e.rd = hex_m[15:8];
                16'hFF04: if (wr) hex_m[23:16] = d;    else e.rd = hex_m[23:16];
                16'hFF08: if (!wr) e.rd = sw[7:0];
                16'hFF09: if (!wr) e.rd = {6'b0, sw[9:8]};
                default:  mapped = 1'b0;
            endcase
        end
        e.err = !mapped || (wr && (a == 16'hFF08 || a == 16'hFF09));
        e.led = led_m;
        e.hex = hex_m;
        return e;
    endfunction

    always @(negedge clk) begin
        if (resp_valid) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response at cycle %0d", cyc);
            end else begin
                mon_e = q.pop_front();
                check("latency", cyc - mon_e.acc, WS);
                if (mon_e.is_rd) check("rdata", resp_rdata, mon_e.rd);
                check("ledr_out", ledr_out, mon_e.led);
                check("hex_val", hex_val, mon_e.hex);
`ifdef SYS_BUS_ERR_EN
                check("resp_err", resp_err, mon_e.err);
`endif
            end
        end else begin
            check("rdata_idle", resp_rdata, 8'h00);
        end
    end

    always @(negedge clk) begin
        if (resp0_valid) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp0: got resp_valid=1 expected no response at cycle %0d", cyc);
            end else begin
                mon0_e = q0.pop_front();
                check("latency0", cyc - mon0_e.acc, 0);
                if (mon0_e.is_rd) check("rdata0", resp0_rdata, mon0_e.rd);
                if (prev0 >= 0) check("interval0", cyc - prev0, 2);
                prev0 = cyc;
            end
        end
    end

    task automatic do_req(input bit wr, input logic [15:0] a, input logic [7:0] d);
        bit seen = 1'b0;
        req_valid = 1'b1; req_wren = wr; req_addr = a; req_wdata = d;
        q.push_back(model(wr, a, d, sw_in, cyc + 1));
        if (wr && int'(a) < 1024) wr_addrs.push_back(int'(a));
        @(posedge clk); #1;
        // Scramble live inputs after acceptance; only the captured copy may matter.
        req_wren = ~wr; req_addr = 16'($urandom); req_wdata = 8'($urandom);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout: got no resp_valid expected one for addr 0x%0h", a);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp0();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = resp0_valid;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout0: got no resp_valid expected one");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d0 [8];
        int          k;
        rst = 1'b0; req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_wdata = '0;
        req0_valid = 1'b0; req0_wren = 1'b0; req0_addr = '0; req0_wdata = '0; sw_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_ledr", ledr_out, 0);
        check("rst_hex", hex_val, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_req(1, 16'h0010, 8'h5A);
        do_req(0, 16'h0010, 8'h00);
        do_req(1, 16'hFF00, 8'hFF);
        do_req(1, 16'hFF01, 8'h03);
        check("ledr_3ff", ledr_out, 10'h3FF);
        do_req(0, 16'hFF01, 8'h00);
        do_req(0, 16'hFF00, 8'h00);
        sw_in = 10'h2A5;
        do_req(0, 16'hFF08, 8'h00);
        do_req(0, 16'hFF09, 8'h00);
        do_req(1, 16'hFF08, 8'h00);
        do_req(0, 16'hFF08, 8'h00);
        do_req(0, 16'h8000, 8'h00);
        do_req(1, 16'hFF03, 8'h77);

        req_valid = 1'b1; req_wren = 1'b1; req_addr = 16'hFF02; req_wdata = 8'h11;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 0);
        end
        check("abort_hex", hex_val, 0);
        check("abort_ledr", ledr_out, 0);
        req_valid = 1'b0;
        led_m = '0; hex_m = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_req(0, 16'hFF02, 8'h00);
        do_req(0, 16'hFF03, 8'h00);
        do_req(0, 16'h0010, 8'h00);

        for (int n = 0; n < 60; n++) begin
            sw_in = 10'($urandom);
            k = $urandom_range(0, 7);
            if (k == 2 && wr_addrs.size() == 0) k = 0;
            case (k)
                0, 1: do_req(1, 16'($urandom_range(0, 1023)), 8'($urandom));
                2:    do_req(0, 16'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]), 8'h00);
                3:    do_req(1, 16'hFF00 + 16'($urandom_range(0, 4)), 8'($urandom));
                4:    do_req(0, 16'hFF00 + 16'($urandom_range(0, 4)), 8'h00);
                5:    do_req(1, 16'hFF08 + 16'($urandom_range(0, 1)), 8'($urandom));
                6: begin
                    a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(16'h0400, 16'hFEFF))
                                                    : 16'($urandom_range(16'hFF0A, 16'hFFFF));
                    do_req($urandom_range(0, 1) == 1, a, 8'($urandom));
                end
                default: do_req(0, 16'hFF08 + 16'($urandom_range(0, 1)), 8'h00);
            endcase
        end

        for (int i = 0; i < 8; i++) d0[i] = 8'($urandom);
        req0_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req0_wren  = (i < 8);
            req0_addr  = 16'((i % 8) * 37 + 5);
            req0_wdata = d0[i % 8];
            q0.push_back('{is_rd: (i >= 8), rd: d0[i % 8], err: 1'b0, led: '0, hex: '0, acc: cyc + 1});
            wait_resp0();
        end
        req0_valid = 1'b0;

        repeat (5) @(posedge clk);
        check("queue_drained", q.size(), 0);
        check("queue0_drained", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_bus_responder.md
SYS_BUS_RESPONDER -- requirements
Module: sys_bus_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2: number of wait cycles between request acceptance and response, legal range 0..15.
REQ-002 Parameter MEM_AW, default 10: address width of the internal byte RAM, giving 2^MEM_AW bytes at base 0x0000.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  initiator request strobe, held high until resp_valid is seen.
REQ-007 req_wren  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  16  byte address.
REQ-009 req_wdata  in  8  write data.
REQ-010 sw_in  in  10  switch inputs, readable through the MMIO map.
REQ-011 resp_valid  out  1  one-cycle response pulse.
REQ-012 resp_rdata  out  8  read data, valid only while resp_valid=1.
REQ-013 ledr_out  out  10  LED register.
REQ-014 hex_val  out  24  six-nibble value register for the seven-segment displays.
REQ-015 resp_err  out  1  unmapped-access flag; present only when SYS_BUS_ERR_EN is defined.

Function
REQ-016 The FSM shall have states IDLE, WAIT, RESP; any other encoding shall return to IDLE on the next edge.
REQ-017 In IDLE with req_valid=1, the block shall capture req_wren, req_addr and req_wdata, then go to WAIT; if WAIT_STATES=0 it shall go directly to RESP.
REQ-018 WAIT shall count captured WAIT_STATES cycles with a 4-bit counter cleared on entry, then go to RESP.
REQ-019 RESP shall last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-020 Latency: resp_valid shall be high in the (WAIT_STATES+1)th cycle after the acceptance edge.
REQ-021 req_* inputs shall be ignored outside IDLE; only the captured copy is used.
REQ-022 If req_valid is still high in IDLE after RESP, it shall be treated as a new request.
REQ-023 Address map:
- 0x0000..2^MEM_AW-1: RAM, read/write.
- 0xFF00: ledr_out[7:0], read/write.
- 0xFF01: ledr_out[9:8] in bits [1:0]; upper bits read 0.
- 0xFF02/0xFF03/0xFF04: hex_val[7:0]/[15:8]/[23:16], read/write.
- 0xFF08/0xFF09: sw_in[7:0] / {6'b0, sw_in[9:8]}, read-only; writes ignored.
- All other addresses are unmapped.
REQ-024 Writes shall commit on the edge entering RESP.
REQ-025 Read data shall be registered on that same edge from the pre-write contents, and held only during RESP; resp_rdata shall be 0x00 otherwise.
REQ-026 An unmapped read shall return 0x00; an unmapped write shall have no effect.
REQ-027 RAM shall not be cleared by reset; its contents are undefined until written.

Reset
REQ-028 On rst=0, the block shall asynchronously force: state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0x00, ledr_out=0, hex_val=0, resp_err=0.
REQ-029 Reset during WAIT or RESP shall abort the transaction with no write committed and no response issued.
REQ-030 After reset release, a request shall be accepted on the first edge with req_valid=1.

Configuration
REQ-031 Macro SYS_BUS_ERR_EN:
- Defined: port resp_err exists and pulses high together with resp_valid for unmapped accesses and for writes to 0xFF08/0xFF09.
- Undefined: port resp_err and its logic are absent, and those accesses complete silently.

Verification
REQ-032 WAIT_STATES=2: write 0x5A to 0x0010, then read 0x0010 -> each resp_valid 3 cycles after acceptance; read returns 0x5A.
REQ-033 Write 0xFF to 0xFF00 and 0x03 to 0xFF01 -> ledr_out=0x3FF; read 0xFF01 -> 0x03.
REQ-034 sw_in=0x2A5; read 0xFF08 and 0xFF09 -> 0xA5 and 0x02; write 0x00 to 0xFF08 -> sw reads unchanged; resp_err=1 with SYS_BUS_ERR_EN.
REQ-035 Read 0x8000 -> 0x00 and resp_err=1 (macro defined); port absent with the macro undefined.
REQ-036 Write 0x11 to 0xFF02, assert rst=0 in WAIT -> no resp_valid; hex_val=0; next request serviced normally.
REQ-037 WAIT_STATES=0 with req_valid held high continuously -> a resp_valid pulse every 2 cycles (back-to-back requests).
